seq_neuron: RTL



---
 rtl/neuron_pkg.sv | 34 +++
 rtl/neuron_postproc.sv | 69 ++++++
 rtl/seq_neuron.sv | 127 ++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and constants for the neuron datapath
// Holds the activation-mode and FSM state enums, the beat-count helper and
// the leaky-ReLU shift. DATA_WIDTH / ACC_WIDTH default to 8 / 32 unless the
// build defines them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package neuron_pkg;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    localparam int LEAKY_SHIFT = 3;

    // Number of MAC beats needed to cover n elements at `lanes` per beat.
    function automatic int calc_beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/neuron_postproc.sv
// rtl/neuron_postproc.sv - bias add, quantize, saturate and activate
// Purely combinational.
// Ports: acc_i   accumulated dot product (ACC_WIDTH signed)
//        bias_i  bias (DATA_WIDTH signed), scaled up by FRAC_BITS here
//        mode_i  activation select
//        y_o     activated result, sat_o quantizer clamped
// Build option SEQ_NEURON_ROUND_EN: round-half-up before the shift.
module neuron_postproc
    import neuron_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ACC_WIDTH  = `ACC_WIDTH,
    parameter int FRAC_BITS  = 4
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    input  logic signed [DATA_WIDTH-1:0] bias_i,
    input  act_mode_e                    mode_i,
    output logic signed [DATA_WIDTH-1:0] y_o,
    output logic                         sat_o
);

    localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;

    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  rnd;
    logic signed [ACC_WIDTH-1:0]  q;
    logic signed [DATA_WIDTH-1:0] qs;
`ifdef SEQ_NEURON_ROUND_EN
    localparam logic [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH + 1)'(1) << (FRAC_BITS - 1);
    logic [ACC_WIDTH:0] wide;
`endif

    always_comb begin
        bias_ext = ACC_WIDTH'(bias_i) <<< FRAC_BITS;
        sum      = acc_i + bias_ext;
`ifdef SEQ_NEURON_ROUND_EN
        // One guard bit catches overflow of the rounding add; a positive
        // addend can only overflow upwards, so clamp to the positive limit.
        wide = {sum[ACC_WIDTH-1], sum} + RND_HALF;
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            rnd = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
        end else begin
            rnd = wide[ACC_WIDTH-1:0];
        end
`else
        rnd = sum;
`endif
        q     = rnd >>> FRAC_BITS;
        sat_o = 1'b0;
        if (q > Y_MAX) begin
            qs    = DATA_WIDTH'(Y_MAX);
            sat_o = 1'b1;
        end else if (q < Y_MIN) begin
            qs    = DATA_WIDTH'(Y_MIN);
            sat_o = 1'b1;
        end else begin
            qs = q[DATA_WIDTH-1:0];
        end

        case (mode_i)
            ACT_RELU:  y_o = qs[DATA_WIDTH-1] ? '0 : qs;
            ACT_LEAKY: y_o = qs[DATA_WIDTH-1] ? (qs >>> LEAKY_SHIFT) : qs;
            default:   y_o = qs;
        endcase
    end

endmodule

// File: rtl/seq_neuron.sv
// rtl/seq_neuron.sv - multi-cycle single neuron with LANES MACs per beat
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready  accept x, w, b, act_mode
//        out_valid/out_ready present y and sat (sat qualified by out_valid)
// Build option SEQ_NEURON_ROUND_EN selects round-half-up quantization
// (handled inside neuron_postproc); timing is identical either way.
module seq_neuron
    import neuron_pkg::*;
#(
    parameter int N          = 4,
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ACC_WIDTH  = `ACC_WIDTH,
    parameter int FRAC_BITS  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]      x,
    input  logic [N-1:0][DATA_WIDTH-1:0]      w,
    input  logic signed [DATA_WIDTH-1:0]      b,
    input  logic [1:0]                        act_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_WIDTH-1:0]      y,
    output logic                              sat
);

    localparam int BEATS = calc_beats(N, LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e                         state_q;
    logic [N-1:0][DATA_WIDTH-1:0]   x_q;
    logic [N-1:0][DATA_WIDTH-1:0]   w_q;
    logic signed [DATA_WIDTH-1:0]   b_q;
    act_mode_e                      mode_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic [BW-1:0]                  beat_q;
    logic signed [DATA_WIDTH-1:0]   y_q;
    logic                           sat_q;
    logic signed [DATA_WIDTH-1:0]   pp_y;
    logic                           pp_sat;
    logic                           last_beat;

    // Accumulator plus this beat's products; lanes past N are padding.
    always_comb begin
        int idx;
        logic signed [2*DATA_WIDTH-1:0] prod;
        idx   = 0;
        prod  = '0;
        acc_d = acc_q;
        for (int l = 0; l < LANES; l++) begin
            idx = int'(beat_q) * LANES + l;
            if (idx < N) begin
                prod  = $signed(x_q[idx]) * $signed(w_q[idx]);
                acc_d = acc_d + ACC_WIDTH'(prod);
            end
        end
    end

    assign last_beat = (beat_q == BW'(BEATS - 1));

    // Post-processing sees the final sum in the same cycle as the last beat.
    neuron_postproc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_postproc (
        .acc_i  (acc_d),
        .bias_i (b_q),
        .mode_i (mode_q),
        .y_o    (pp_y),
        .sat_o  (pp_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            w_q     <= '0;
            b_q     <= '0;
            mode_q  <= ACT_IDENT;
            acc_q   <= '0;
            beat_q  <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q     <= x;
                        w_q     <= w;
                        b_q     <= b;
                        mode_q  <= act_mode_e'(act_mode);
                        acc_q   <= '0;
                        beat_q  <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (last_beat) begin
                        y_q     <= pp_y;
                        sat_q   <= pp_sat;
                        state_q <= S_OUT;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign y         = y_q;
    assign sat       = sat_q;

endmodule
